// File: rtl/aud_pkg.sv
// Shared audio codec definitions for the ADC receive and DAC transmit paths.
package aud_pkg;

    typedef enum logic [1:0] {
        HUNT,
        LEFT,
        RIGHT
    } ch_state_t;

    localparam int unsigned AUD_DATA_WIDTH  = 16;
    localparam int unsigned AUD_CHANNEL_NUM = 2;
    localparam int unsigned AUD_SAMPLE_RATE = 48000;

    // Source select for the DAC feed: memory reader, ADC loopback, tone, mute.
    typedef enum logic [1:0] {
        SRC_MEM,
        SRC_ADC_LOOP,
        SRC_TONE,
        SRC_MUTE
    } src_sel_t;

endpackage

// File: rtl/aud_adc_rx_if.sv
// Stereo sample-pair valid/ready handshake from the ADC receiver to its consumer.
interface aud_adc_rx_if
    import aud_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AUD_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] oLEFT_DATA;
    logic [DATA_WIDTH-1:0] oRIGHT_DATA;
    logic                  oSAMPLE_VALID;
    logic                  iSAMPLE_READY;

    modport master (
        output oLEFT_DATA,
        output oRIGHT_DATA,
        output oSAMPLE_VALID,
        input  iSAMPLE_READY
    );

    modport slave (
        input  oLEFT_DATA,
        input  oRIGHT_DATA,
        input  oSAMPLE_VALID,
        output iSAMPLE_READY
    );
endinterface

// File: rtl/aud_in_sync.sv
// Multi-flop synchroniser for the codec pins; bit 0 is the bit clock and gets a
// history flop to produce a single-cycle rise strobe.
module aud_in_sync
    import aud_pkg::*;
#(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             iCLK_18_4,
    input  logic             iRST_N,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:1] synced,
    output logic             rise
);
    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic             hist_q;

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
            hist_q <= 1'b0;
        end else begin
            stage_q[0] <= pin;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            hist_q <= stage_q[SYNC_STAGES-1][0];
        end
    end

    // Non-clock pins are taken from the same stage the rise is detected on.
    assign synced = stage_q[SYNC_STAGES-1][WIDTH-1:1];
    assign rise   = stage_q[SYNC_STAGES-1][0] & ~hist_q;

endmodule

// File: rtl/aud_adc_rx.sv
// Codec ADC serial receiver: deserialises BCK/LRCK/DATA MSB-first into stereo
// pairs and presents each left/right pair on a single-entry valid/ready register.
module aud_adc_rx
    import aud_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = AUD_DATA_WIDTH,
    parameter int unsigned I2S_DELAY       = 0,
    parameter logic        LEFT_LRCK_LEVEL = 1'b1,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic         iCLK_18_4,
    input  logic         iRST_N,
    input  logic         iAUD_BCK,
    input  logic         iAUD_ADCLRCK,
    input  logic         iAUD_ADCDAT,
    aud_adc_rx_if.master smp,
    output logic         oOVERFLOW,
    output logic         oSHORT_WORD,
    input  logic         iSTAT_CLR
);
    localparam int unsigned    CW       = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

    logic [2:1] synced;
    logic       bck_rise;
    logic       lrck_s;
    logic       dat_s;

    aud_in_sync #(
        .WIDTH       (3),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .iCLK_18_4 (iCLK_18_4),
        .iRST_N    (iRST_N),
        .pin       ({iAUD_ADCDAT, iAUD_ADCLRCK, iAUD_BCK}),
        .synced    (synced),
        .rise      (bck_rise)
    );

    assign lrck_s = synced[1];
    assign dat_s  = synced[2];

    ch_state_t             state_q, state_d;
    logic                  lrck_prev_q;
    logic                  lrck_seen_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] left_hold_q;
    logic [DATA_WIDTH-1:0] pair_left_q;
    logic [DATA_WIDTH-1:0] pair_right_q;
    logic                  push_q;

    logic                  boundary;
    logic                  load_left;
    logic                  push;
    logic                  capture;
    logic                  short_evt;
    logic [DATA_WIDTH-1:0] word;

    logic [DATA_WIDTH-1:0] left_q;
    logic [DATA_WIDTH-1:0] right_q;
    logic                  valid_q;
    logic                  ovf_q;
    logic                  short_q;

    // The first BCK rise after reset only records LRCK, so a stream resumed
    // mid-word can never look like a fresh channel boundary.
    assign boundary = bck_rise && lrck_seen_q && (lrck_s != lrck_prev_q);

    assign word = shift_q << (CNT_FULL - cnt_q);

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (boundary) begin
            unique case (state_q)
                HUNT:    if (lrck_s == LEFT_LRCK_LEVEL) state_d = LEFT;
                LEFT:    state_d = RIGHT;
                RIGHT:   state_d = LEFT;
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        load_left = 1'b0;
        push      = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            LEFT: begin
                load_left = boundary;
                capture   = bck_rise && !boundary && (cnt_q < CNT_FULL);
            end
            RIGHT: begin
                push    = boundary;
                capture = bck_rise && !boundary && (cnt_q < CNT_FULL);
            end
            default: ;
        endcase
        short_evt = (load_left || push) && (cnt_q < CNT_FULL);
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            lrck_prev_q  <= 1'b0;
            lrck_seen_q  <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            left_hold_q  <= '0;
            pair_left_q  <= '0;
            pair_right_q <= '0;
            push_q       <= 1'b0;
        end else begin
            if (bck_rise) begin
                lrck_prev_q <= lrck_s;
                lrck_seen_q <= 1'b1;
            end
            if (boundary) begin
                if (I2S_DELAY == 0) begin
                    shift_q <= DATA_WIDTH'(dat_s);
                    cnt_q   <= CW'(1);
                end else begin
                    shift_q <= '0;
                    cnt_q   <= '0;
                end
            end else if (capture) begin
                shift_q <= {shift_q[DATA_WIDTH-2:0], dat_s};
                cnt_q   <= cnt_q + CW'(1);
            end
            if (load_left) begin
                left_hold_q <= word;
            end
            push_q <= push;
            if (push) begin
                pair_left_q  <= left_hold_q;
                pair_right_q <= word;
            end
        end
    end

    // A push that meets an accepting consumer replaces the held pair directly,
    // so valid stays high across back-to-back pairs.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            if (push_q && (!valid_q || smp.iSAMPLE_READY)) begin
                left_q  <= pair_left_q;
                right_q <= pair_right_q;
                valid_q <= 1'b1;
            end else if (valid_q && smp.iSAMPLE_READY) begin
                valid_q <= 1'b0;
            end

            if (push_q && valid_q && !smp.iSAMPLE_READY) begin
                ovf_q <= 1'b1;
            end else if (iSTAT_CLR) begin
                ovf_q <= 1'b0;
            end

            if (short_evt) begin
                short_q <= 1'b1;
            end else if (iSTAT_CLR) begin
                short_q <= 1'b0;
            end
        end
    end

    assign smp.oLEFT_DATA    = left_q;
    assign smp.oRIGHT_DATA   = right_q;
    assign smp.oSAMPLE_VALID = valid_q;
    assign oOVERFLOW         = ovf_q;
    assign oSHORT_WORD       = short_q;

endmodule
